disp_update_arbiter: RTL

- Owns the 16-entry x 16-bit display value bank that feeds the text generator's 256-bit data_raw bus.
- Arbitrates update requests from several sources (debounced button, 1 s tick, host writes) with round-robin priority and applies each granted op to a shadow bank.
- Copies the shadow bank to the live output only at the start of vertical blanking, so the screen never shows a half-updated frame.

---
 rtl/disp_arb_pkg.sv | 34 +++
 rtl/disp_update_arbiter_rr_arbiter.sv | 43 ++++
 rtl/disp_update_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/disp_arb_pkg.sv
// ----------------------------------------------------------------------------
// disp_arb_pkg
// Shared definitions for the display update arbiter: op encoding, bank
// geometry, the power-on bank contents and an entry slice helper.
// Bank layout: entry k lives at bits [16*(15-k) +: 16] of the 256-bit bank,
// so entry 0 is the most significant word.
// ----------------------------------------------------------------------------
package disp_arb_pkg;

    localparam int N_ENT  = 16;
    localparam int DATA_W = 16;
    localparam int BANK_W = N_ENT * DATA_W;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Entry k holds the value k after reset.
    localparam logic [BANK_W-1:0] INIT_BANK = {
        16'h0000, 16'h0001, 16'h0002, 16'h0003,
        16'h0004, 16'h0005, 16'h0006, 16'h0007,
        16'h0008, 16'h0009, 16'h000A, 16'h000B,
        16'h000C, 16'h000D, 16'h000E, 16'h000F
    };

    function automatic logic [DATA_W-1:0] get_entry(input logic [BANK_W-1:0] bank,
                                                     input int k);
        return bank[DATA_W*(N_ENT-1-k) +: DATA_W];
    endfunction

endpackage

// File: rtl/disp_update_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The pointer register lives in the
// parent; this block only picks the winner and proposes the next pointer.
// Ports:
//   req      in  N_REQ  request levels
//   ptr      in  PTR_W  requester with highest priority this cycle
//   enable   in  1      arbitration allowed this cycle
//   gnt      out N_REQ  one-hot winner (all zero when nothing wins)
//   valid    out 1      a winner was found
//   next_ptr out PTR_W  winner + 1, wrapped to N_REQ
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic             valid,
    output logic [PTR_W-1:0] next_ptr
);

    // Walk the requesters in priority order starting at ptr; the first one
    // found with its request raised wins. The inner loop keeps every bit
    // select indexed by a loop constant.
    always_comb begin
        gnt      = '0;
        valid    = 1'b0;
        next_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (enable && !valid && req[j] && (j == ((int'(ptr) + i) % N_REQ))) begin
                    gnt[j]   = 1'b1;
                    valid    = 1'b1;
                    next_ptr = PTR_W'((j + 1) % N_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/disp_update_arbiter.sv
// ----------------------------------------------------------------------------
// disp_update_arbiter
// Owns the 16 x 16-bit display value bank. Update requests from several
// sources are arbitrated round-robin and applied to a shadow bank; the shadow
// is copied to the live bank (data_raw) only at the start of vertical blanking
// so a frame never shows a half-applied set of updates.
// Ports:
//   clk        in  1         system clock
//   reset      in  1         asynchronous, active-high
//   req        in  N_REQ     request level per requester, held until granted
//   req_op     in  2*N_REQ   op per requester (LOAD/INC/DEC/CLEAR)
//   req_idx    in  4*N_REQ   target entry per requester
//   req_all    in  N_REQ     apply the op to every entry
//   req_wdata  in  16*N_REQ  LOAD data per requester
//   vblank     in  1         high while outside the visible region
//   gnt        out N_REQ     one-hot, one-cycle grant pulse
//   data_raw   out 256       live bank, entry k at [16*(15-k) +: 16]
//   dirty      out 1         shadow holds changes not yet committed
//   commit     out 1         one-cycle pulse after the live bank is updated
// Build option:
//   DISP_ARB_SATURATE_EN  INC/DEC saturate at 0xFFFF/0x0000 instead of wrapping
// ----------------------------------------------------------------------------
module disp_update_arbiter
    import disp_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [2*N_REQ-1:0]      req_op,
    input  logic [4*N_REQ-1:0]      req_idx,
    input  logic [N_REQ-1:0]        req_all,
    input  logic [16*N_REQ-1:0]     req_wdata,
    input  logic                    vblank,
    output logic [N_REQ-1:0]        gnt,
    output logic [BANK_W-1:0]       data_raw,
    output logic                    dirty,
    output logic                    commit
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_valid;
    logic [PTR_W-1:0]  arb_next_ptr;
    logic              vblank_q;
    logic              vblank_rise;
    logic [BANK_W-1:0] shadow;
    logic [BANK_W-1:0] shadow_next;
    logic [1:0]        win_op;
    logic [3:0]        win_idx;
    logic              win_all;
    logic [DATA_W-1:0] win_wdata;

    function automatic logic [DATA_W-1:0] apply_op(input logic [DATA_W-1:0] cur,
                                                    input op_e op,
                                                    input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] res;
        res = cur;
        case (op)
            OP_LOAD:  res = wd;
`ifdef DISP_ARB_SATURATE_EN
            OP_INC:   res = (cur == {DATA_W{1'b1}}) ? cur : cur + 16'd1;
            OP_DEC:   res = (cur == '0) ? cur : cur - 16'd1;
`else
            OP_INC:   res = cur + 16'd1;
            OP_DEC:   res = cur - 16'd1;
`endif
            OP_CLEAR: res = '0;
            default:  res = cur;
        endcase
        return res;
    endfunction

    // A new winner is only picked while no grant is outstanding, which is what
    // limits throughput to one op every two cycles.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req      (req),
        .ptr      (ptr),
        .enable   (gnt == '0),
        .gnt      (arb_gnt),
        .valid    (arb_valid),
        .next_ptr (arb_next_ptr)
    );

    assign vblank_rise = vblank & ~vblank_q;

    // Pull the winning requester's op fields out of the packed request buses.
    always_comb begin
        win_op    = '0;
        win_idx   = '0;
        win_all   = 1'b0;
        win_wdata = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (arb_gnt[r]) begin
                win_op    = req_op[2*r +: 2];
                win_idx   = req_idx[4*r +: 4];
                win_all   = req_all[r];
                win_wdata = req_wdata[16*r +: 16];
            end
        end
    end

    // Shadow bank after the granted op, evaluated per entry so a sweep over
    // all entries saturates or wraps each entry independently.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < N_ENT; k++) begin
            if (arb_valid && (win_all || (win_idx == 4'(k)))) begin
                shadow_next[DATA_W*(N_ENT-1-k) +: DATA_W] =
                    apply_op(get_entry(shadow, k), op_e'(win_op), win_wdata);
            end
        end
    end

    // Grant, apply and commit share one edge. When a commit and an apply land
    // together the live bank takes the shadow as it was before the apply, and
    // the apply keeps dirty set so it goes out on the following vblank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= INIT_BANK;
            data_raw <= INIT_BANK;
            gnt      <= '0;
            dirty    <= 1'b0;
            commit   <= 1'b0;
            ptr      <= '0;
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
            gnt      <= arb_gnt;
            commit   <= 1'b0;
            if (arb_valid) begin
                shadow <= shadow_next;
                ptr    <= arb_next_ptr;
            end
            if (vblank_rise && dirty) begin
                data_raw <= shadow;
                commit   <= 1'b1;
                dirty    <= arb_valid;
            end else if (arb_valid) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule
